// File: rtl/jtcop_mcu_pkg.sv
// Shared constants for the MCU mailbox: MCU port-2 control bit positions,
// edge-detector lane map and IRQ FSM encoding.
package jtcop_mcu_pkg;

  localparam int P2_IRQ   = 2;
  localparam int P2_RD_LO = 4;
  localparam int P2_RD_HI = 5;
  localparam int P2_WR_LO = 6;
  localparam int P2_WR_HI = 7;

  // Edge-detector lanes: the first NUM_P2 follow p2_in on cen, the rest follow the main bus every clk
  localparam int L_IRQ    = 0;
  localparam int L_RD_LO  = 1;
  localparam int L_RD_HI  = 2;
  localparam int L_WR_LO  = 3;
  localparam int L_WR_HI  = 4;
  localparam int L_SEC_WR = 5;
  localparam int L_SEC_RD = 6;
  localparam int NUM_P2   = 5;
  localparam int NUM_LANES = 7;

  localparam logic [1:0] ST_IDLE_ENC    = 2'd0;
  localparam logic [1:0] ST_ASSERT_ENC  = 2'd1;
  localparam logic [1:0] ST_HOLDOFF_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = ST_IDLE_ENC,
    ST_ASSERT  = ST_ASSERT_ENC,
    ST_HOLDOFF = ST_HOLDOFF_ENC
  } irq_st_e;

endpackage

// File: rtl/jtcop_mcu_mailbox_if.sv
// Main-CPU side of the mailbox: write/ack strobes, data words and the IRQ line.
interface jtcop_mcu_mailbox_if;
  logic        sec_wr;
  logic        sec_rd;
  logic [15:0] main_dout;
  logic [15:0] main_din;
  logic        sec2;

  modport master (output sec_wr, sec_rd, main_dout, input  main_din, sec2);
  modport slave  (input  sec_wr, sec_rd, main_dout, output main_din, sec2);
endinterface

// File: rtl/jtcop_mcu_edge.sv
// Enable-qualified rise/fall detector. The first enabled sample after reset
// only primes the history, so levels held across reset never look like edges.
module jtcop_mcu_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic cen,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic last_q, last_d;
  logic armed_q, armed_d;

  always_comb begin
    last_d  = cen ? din : last_q;
    armed_d = armed_q | cen;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q  <= RST_VAL;
      armed_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      armed_q <= armed_d;
    end
  end

  assign rise = cen & armed_q &  din & ~last_q;
  assign fall = cen & armed_q & ~din &  last_q;
endmodule

// File: rtl/jtcop_mcu_mailbox.sv
// Main CPU <-> MCU mailbox: 16-bit word down to the MCU over port 0, 16-bit
// reply up to the main CPU, and a rate-limited IRQ (sec2) toward the main CPU.
module jtcop_mcu_mailbox
  import jtcop_mcu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 cen,
  jtcop_mcu_mailbox_if.slave   mb,
  input  logic [7:0]           p0_in,
  output logic [7:0]           p0_out,
  input  logic [7:0]           p2_in,
  output logic                 int0n,
  output logic                 ovr
);
  logic [NUM_LANES-1:0] ln_in, ln_cen, ln_rise, ln_fall;

  assign ln_in  = {mb.sec_rd, mb.sec_wr, p2_in[P2_WR_HI], p2_in[P2_WR_LO],
                   p2_in[P2_RD_HI], p2_in[P2_RD_LO], p2_in[P2_IRQ]};
  assign ln_cen = {2'b11, {NUM_P2{cen}}};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_edge
    jtcop_mcu_edge #(.RST_VAL(i < NUM_P2 ? 1'b1 : 1'b0)) u_edge (
      .clk  (clk),
      .rstn (rstn),
      .cen  (ln_cen[i]),
      .din  (ln_in[i]),
      .rise (ln_rise[i]),
      .fall (ln_fall[i])
    );
  end

  logic unused_ok;
  assign unused_ok = ^{ln_fall[L_IRQ], ln_fall[L_WR_LO], ln_fall[L_WR_HI],
                       ln_fall[L_SEC_WR], ln_fall[L_SEC_RD], p2_in[1:0], p2_in[3]};

  logic [15:0] rx_q, rx_d, main_din_q, main_din_d;
  logic [7:0]  tx_lo_q, tx_lo_d, p0_out_q, p0_out_d;
  logic        rx_full_q, rx_full_d, int0n_q, int0n_d, ovr_q, ovr_d;

  always_comb begin
    rx_d       = rx_q;
    rx_full_d  = rx_full_q;
    ovr_d      = ovr_q;
    p0_out_d   = p0_out_q;
    tx_lo_d    = tx_lo_q;
    main_din_d = main_din_q;
    if (ln_rise[L_RD_LO] | ln_rise[L_RD_HI]) p0_out_d = 8'hff;
    if (ln_fall[L_RD_LO]) p0_out_d = rx_q[7:0];
    if (ln_fall[L_RD_HI]) begin
      p0_out_d  = rx_q[15:8];
      rx_full_d = 1'b0;
    end
    // A new word beats a simultaneous hi read; the old word was still delivered, so no overrun
    if (ln_rise[L_SEC_WR]) begin
      rx_d      = mb.main_dout;
      rx_full_d = 1'b1;
      if (rx_full_q & ~ln_fall[L_RD_HI]) ovr_d = 1'b1;
    end
    if (ln_rise[L_WR_LO]) tx_lo_d = p0_in;
    if (ln_rise[L_WR_HI]) main_din_d = {p0_in, tx_lo_d};
    int0n_d = ~rx_full_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_q       <= 16'h0;
      rx_full_q  <= 1'b0;
      ovr_q      <= 1'b0;
      p0_out_q   <= 8'hff;
      tx_lo_q    <= 8'h0;
      main_din_q <= 16'h0;
      int0n_q    <= 1'b1;
    end else begin
      rx_q       <= rx_d;
      rx_full_q  <= rx_full_d;
      ovr_q      <= ovr_d;
      p0_out_q   <= p0_out_d;
      tx_lo_q    <= tx_lo_d;
      main_din_q <= main_din_d;
      int0n_q    <= int0n_d;
    end
  end

  irq_st_e st_q;
  logic    sec2_q, pend_q, cnt_q;
  logic    irq_rise, ack_rise;

  assign irq_rise = ln_rise[L_IRQ];
  assign ack_rise = ln_rise[L_SEC_RD];

  // sec2 stays low for two clk after an ack before a pending request may re-assert it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q   <= ST_IDLE;
      sec2_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q  <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: if (irq_rise) begin
          st_q   <= ST_ASSERT;
          sec2_q <= 1'b1;
          pend_q <= 1'b0;
        end
        ST_ASSERT: begin
          if (irq_rise) pend_q <= 1'b1;
          if (ack_rise) begin
            st_q   <= ST_HOLDOFF;
            sec2_q <= 1'b0;
            cnt_q  <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          if (!cnt_q) begin
            cnt_q <= 1'b1;
            if (irq_rise) pend_q <= 1'b1;
          end else if (pend_q | irq_rise) begin
            st_q   <= ST_ASSERT;
            sec2_q <= 1'b1;
            pend_q <= 1'b0;
          end else begin
            st_q <= ST_IDLE;
          end
        end
        default: begin
          st_q   <= ST_IDLE;
          sec2_q <= 1'b0;
        end
      endcase
    end
  end

  assign mb.main_din = main_din_q;
  assign mb.sec2     = sec2_q;
  assign p0_out      = p0_out_q;
  assign int0n       = int0n_q;
  assign ovr         = ovr_q;
endmodule

// File: tb/tb_jtcop_mcu_mailbox.sv
// Directed bench for jtcop_mcu_mailbox: mailbox transfers both ways, IRQ
// holdoff/pending behaviour, overrun, collision and mid-transfer reset.
module tb_jtcop_mcu_mailbox;
  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       cen = 1'b1;
  logic [7:0] p0_in = 8'h00;
  logic [7:0] p0_out;
  logic [7:0] p2_in = 8'hff;
  logic       int0n, ovr;
  int         n_chk = 0, n_pass = 0;

  jtcop_mcu_mailbox_if mb_if();

  jtcop_mcu_mailbox dut (
    .clk    (clk),
    .rstn   (rstn),
    .cen    (cen),
    .mb     (mb_if.slave),
    .p0_in  (p0_in),
    .p0_out (p0_out),
    .p2_in  (p2_in),
    .int0n  (int0n),
    .ovr    (ovr)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic main_wr(input logic [15:0] w);
    mb_if.main_dout = w;
    mb_if.sec_wr    = 1'b1;
    tick();
    mb_if.sec_wr    = 1'b0;
    tick();
  endtask

  task automatic irq_pulse();
    p2_in[2] = 1'b0;
    tick();
    p2_in[2] = 1'b1;
    tick();
  endtask

  initial begin
    mb_if.sec_wr = 1'b0;
    mb_if.sec_rd = 1'b0;
    mb_if.main_dout = 16'h0;
    #1 rstn = 1'b0;
    tick(3);
    chk("rst_p0_out", {8'h0, p0_out}, 16'h00ff);
    chk("rst_int0n", {15'h0, int0n}, 16'h1);
    chk("rst_sec2", {15'h0, mb_if.sec2}, 16'h0);
    chk("rst_ovr", {15'h0, ovr}, 16'h0);
    chk("rst_main_din", mb_if.main_din, 16'h0000);
    rstn = 1'b1;
    tick(2);

    // main write, then MCU reads lo and hi
    mb_if.main_dout = 16'h1234;
    mb_if.sec_wr = 1'b1;
    chk("int0n_before_edge", {15'h0, int0n}, 16'h1);
    tick();
    chk("int0n_after_wr", {15'h0, int0n}, 16'h0);
    mb_if.sec_wr = 1'b1;
    tick();
    chk("held_wr_int0n", {15'h0, int0n}, 16'h0);
    mb_if.sec_wr = 1'b0;
    p2_in = 8'hef; tick();
    chk("rd_lo_data", {8'h0, p0_out}, 16'h0034);
    chk("int0n_after_lo", {15'h0, int0n}, 16'h0);
    p2_in = 8'hff; tick();
    chk("rd_lo_release", {8'h0, p0_out}, 16'h00ff);
    p2_in = 8'hdf; tick();
    chk("rd_hi_data", {8'h0, p0_out}, 16'h0012);
    chk("int0n_after_hi", {15'h0, int0n}, 16'h1);
    p2_in = 8'hff; tick();
    chk("rd_hi_release", {8'h0, p0_out}, 16'h00ff);

    // MCU port ignored while cen is low
    cen = 1'b0;
    p2_in = 8'hef; tick();
    chk("cen_gate", {8'h0, p0_out}, 16'h00ff);
    cen = 1'b1; tick();
    chk("cen_resume", {8'h0, p0_out}, 16'h0034);
    p2_in = 8'hff; tick();

    // MCU writes lo then hi
    p0_in = 8'hcd; p2_in = 8'hbf; tick();
    p2_in = 8'hff; tick();
    chk("main_din_after_lo", mb_if.main_din, 16'h0000);
    p0_in = 8'hab; p2_in = 8'h7f; tick();
    chk("main_din_hi_fall", mb_if.main_din, 16'h0000);
    p2_in = 8'hff; tick();
    chk("main_din_word", mb_if.main_din, 16'habcd);

    // single IRQ with 2-clk holdoff then idle
    irq_pulse();
    chk("sec2_assert", {15'h0, mb_if.sec2}, 16'h1);
    mb_if.sec_rd = 1'b1; tick();
    chk("sec2_hold0", {15'h0, mb_if.sec2}, 16'h0);
    mb_if.sec_rd = 1'b0; tick();
    chk("sec2_hold1", {15'h0, mb_if.sec2}, 16'h0);
    tick(3);
    chk("sec2_idle", {15'h0, mb_if.sec2}, 16'h0);
    mb_if.sec_rd = 1'b1; tick();
    mb_if.sec_rd = 1'b0; tick();
    chk("sec_rd_idle_noop", {15'h0, mb_if.sec2}, 16'h0);

    // pending request re-asserts once, third request dropped
    irq_pulse();
    irq_pulse();
    irq_pulse();
    chk("sec2_still_high", {15'h0, mb_if.sec2}, 16'h1);
    mb_if.sec_rd = 1'b1; tick();
    chk("pend_hold0", {15'h0, mb_if.sec2}, 16'h0);
    mb_if.sec_rd = 1'b0; tick();
    chk("pend_hold1", {15'h0, mb_if.sec2}, 16'h0);
    tick();
    chk("pend_reassert", {15'h0, mb_if.sec2}, 16'h1);
    mb_if.sec_rd = 1'b1; tick();
    mb_if.sec_rd = 1'b0; tick(4);
    chk("third_dropped", {15'h0, mb_if.sec2}, 16'h0);

    // overrun: second word overwrites the first
    chk("ovr_clear", {15'h0, ovr}, 16'h0);
    main_wr(16'h0001);
    main_wr(16'h0002);
    chk("ovr_set", {15'h0, ovr}, 16'h1);
    p2_in = 8'hdf; tick();
    chk("ovr_rd_hi", {8'h0, p0_out}, 16'h0000);
    p2_in = 8'hff; tick();
    p2_in = 8'hef; tick();
    chk("ovr_rd_lo", {8'h0, p0_out}, 16'h0002);
    p2_in = 8'hff; tick();

    // main write colliding with hi read: new word wins
    main_wr(16'h5566);
    mb_if.main_dout = 16'h789a;
    mb_if.sec_wr = 1'b1; p2_in = 8'hdf; tick();
    chk("coll_old_hi", {8'h0, p0_out}, 16'h0055);
    chk("coll_int0n", {15'h0, int0n}, 16'h0);
    mb_if.sec_wr = 1'b0; p2_in = 8'hff; tick();
    p2_in = 8'hef; tick();
    chk("coll_new_lo", {8'h0, p0_out}, 16'h009a);
    p2_in = 8'hff; tick();
    chk("coll_int0n_held", {15'h0, int0n}, 16'h0);

    // reset mid-handshake
    irq_pulse();
    chk("pre_rst_sec2", {15'h0, mb_if.sec2}, 16'h1);
    #2 rstn = 1'b0; p2_in = 8'h00;
    #1;
    chk("arst_sec2", {15'h0, mb_if.sec2}, 16'h0);
    chk("arst_int0n", {15'h0, int0n}, 16'h1);
    chk("arst_p0_out", {8'h0, p0_out}, 16'h00ff);
    chk("arst_ovr", {15'h0, ovr}, 16'h0);
    chk("arst_main_din", mb_if.main_din, 16'h0000);
    tick(2);
    rstn = 1'b1;
    tick(4);
    chk("post_rst_p0_out", {8'h0, p0_out}, 16'h00ff);
    chk("post_rst_main_din", mb_if.main_din, 16'h0000);
    chk("post_rst_sec2", {15'h0, mb_if.sec2}, 16'h0);
    chk("post_rst_int0n", {15'h0, int0n}, 16'h1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/jtcop_mcu_mailbox.md
JTCOP_MCU_MAILBOX -- requirements
Module: jtcop_mcu_mailbox

Interface
REQ-001 The clock and reset ports SHALL be as follows: one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  system clock, same domain as main CPU bus.
REQ-003 rstn  in  1  asynchronous, active-low reset.
REQ-004 cen  in  1  MCU clock enable; all MCU-port sampling qualified by it.
REQ-005 sec_wr  in  1  main CPU write strobe to the mailbox (level, may span several clk).
REQ-006 sec_rd  in  1  main CPU read/acknowledge strobe (level).
REQ-007 main_dout  in  16  word written by the main CPU.
REQ-008 main_din  out  16  reply word returned to the main CPU.
REQ-009 sec2  out  1  interrupt request to the main CPU; main detects its rising edge.
REQ-010 p0_in  in  8  MCU port 0 output (data written by the MCU).
REQ-011 p0_out  out  8  data presented to MCU port 0.
REQ-012 p2_in  in  8  MCU port 2 control bits: [2] irq_main, [4] rd_lo_n, [5] rd_hi_n, [6] wr_lo_n, [7] wr_hi_n.
REQ-013 int0n  out  1  MCU external interrupt, active low.
REQ-014 ovr  out  1  sticky overrun flag, for debug.

Function
REQ-015 A rising edge of sec_wr SHALL capture main_dout into rx[15:0] on that clk, set rx_full and drive int0n low on the next clk; a held sec_wr SHALL NOT recapture.
REQ-016 A sec_wr edge while rx_full=1 SHALL overwrite rx and set ovr.
REQ-017 MCU control edges SHALL be detected on cen cycles only, by comparing p2_in with its value at the previous cen.
REQ-018 A falling rd_lo_n SHALL load p0_out with rx[7:0]; a falling rd_hi_n SHALL load p0_out with rx[15:8], clear rx_full and release int0n.
REQ-019 p0_out SHALL return to 8'hff on the first cen after the active read line rises.
REQ-020 A rising wr_lo_n SHALL latch p0_in into tx_lo; a rising wr_hi_n SHALL load main_din with {p0_in, tx_lo} in one clk, so main_din never shows a half-updated word.
REQ-021 If a sec_wr edge and a falling rd_hi_n occur on the same clk, the new word SHALL win: rx updated, rx_full stays 1, int0n stays low.
REQ-022 The IRQ FSM SHALL have three states: IDLE (sec2=0), ASSERT (sec2=1), HOLDOFF (sec2=0, 2-clk counter).
REQ-023 IDLE->ASSERT on a rising irq_main.
REQ-024 ASSERT->HOLDOFF on a rising edge of sec_rd.
REQ-025 HOLDOFF->IDLE after 2 clk, or HOLDOFF->ASSERT after 2 clk if a request is pending.
REQ-026 A rising irq_main seen in ASSERT or HOLDOFF SHALL set a one-deep pend flag; further requests while pend=1 SHALL be dropped; pend SHALL clear on entry to ASSERT.
REQ-027 sec_rd SHALL have no effect in IDLE or HOLDOFF.

Reset
REQ-028 While rstn=0: rx=0, tx_lo=0, main_din=16'h0, p0_out=8'hff, rx_full=0, int0n=1, sec2=0, pend=0, ovr=0, FSM=IDLE, edge registers=inactive levels (p2 sampled as 8'hff, sec_wr/sec_rd as 0).
REQ-029 Reset asserted mid-handshake SHALL abandon the transfer; after release, no edge SHALL be inferred from pre-reset levels.

Structure
REQ-030 The p2 bit positions and the FSM state encoding SHALL be localparams in a shared jtcop_mcu_pkg package.
REQ-031 One sub-module is natural: jtcop_mcu_edge, a cen-qualified rise/fall detector instantiated per control line.

Verification
REQ-032 Main write 16'h1234, then MCU rd_lo then rd_hi -> p0_out 8'h34, then 8'h12; int0n low from clk+1 after the write until the rd_hi edge.
REQ-033 MCU writes lo 8'hCD, then hi 8'hAB -> main_din holds its old value until the hi edge, then 16'hABCD.
REQ-034 irq_main rise -> sec2=1; sec_rd pulse -> sec2=0 for exactly 2 clk, then IDLE.
REQ-035 Two irq_main rises while sec2=1, then sec_rd -> HOLDOFF 2 clk, then sec2 rises once more; the third request is dropped.
REQ-036 Two main writes (16'h0001, 16'h0002) with no MCU read -> ovr=1, hi read returns 8'h00, lo read returns 8'h02.
REQ-037 rstn low while sec2=1 and rx_full=1 -> all outputs at reset values; after release with p2_in=8'h00, no MCU read or write is decoded.
